// File: rtl/rotate_arbiter.sv
// Two-requester round-robin arbiter feeding a single-entry rotate-left result register.
// Optional completion counter on port done_cnt when ROTATE_ARBITER_CNT_EN is defined.
module rotate_arbiter #(
    parameter int START_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [3:0] req0_data,
    input  logic [1:0] req0_amt,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_data,
    input  logic [1:0] req1_amt,
    output logic       req1_ready,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic       out_id,
    input  logic       out_ready
`ifdef ROTATE_ARBITER_CNT_EN
    ,
    output logic [7:0] done_cnt
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] data_q, data_d;
    logic       id_q, id_d;
    logic       prio_q, prio_d;

    logic       has_req;
    logic       accept_ok;
    logic       grant_id;
    logic       xfer;
    logic [3:0] sel_data;
    logic [1:0] sel_amt;
    logic [3:0] rot_data;

    // With only one requester valid it wins outright; the pointer only breaks ties.
    assign has_req   = req0_valid | req1_valid;
    assign grant_id  = (req0_valid & req1_valid) ? prio_q : req1_valid;
    assign accept_ok = (state_q == EMPTY) | out_ready;
    assign xfer      = has_req & accept_ok;
    assign sel_data  = grant_id ? req1_data : req0_data;
    assign sel_amt   = grant_id ? req1_amt  : req0_amt;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            localparam logic [1:0] POS = 2'(gi);
            logic [1:0] src_idx;
            assign src_idx      = POS - sel_amt;
            assign rot_data[gi] = sel_data[src_idx];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= 4'b0000;
            id_q    <= 1'b0;
            prio_q  <= 1'(START_PRIO);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        prio_d  = prio_q;
        if (xfer) begin
            state_d = FULL;
            data_d  = rot_data;
            id_d    = grant_id;
            prio_d  = ~grant_id;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    // Ready is forced low during reset because the cleared state alone would look EMPTY.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && xfer) begin
            req0_ready = ~grant_id;
            req1_ready = grant_id;
        end
        out_valid = (state_q == FULL);
        out_data  = data_q;
        out_id    = id_q;
    end

`ifdef ROTATE_ARBITER_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (state_q == FULL && out_ready) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign done_cnt = cnt_q;
`endif

endmodule
